hazard_ctrl: RTL

Pipeline hazard and stall controller for each core of the five-stage MIPS pipeline. It works alongside the forwarding unit. It generates:
- latch enables and flushes for IF/ID, ID/EX, EX/MEM and MEM/WB;
- the PC enable;
- a data-request mask that stops a completed data access from repeating while fetch is still waiting.

It also detects load-use hazards, applies branch/jump redirects resolved in MEM, latches halt, and counts stall cycles.

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall, flush, redirect and halt control for the five-stage core
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             memRead_ex,
  input  logic [4:0]       regDest_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             useRt_id,
  input  logic             redirect_mem,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             dmem_mask,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DDONE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_dmem_mask;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_dreq;
  logic w_advance;
  logic w_loaduse;
  logic w_hold_front;

  // A data access that already completed while fetch waited is masked so it is not reissued.
  assign w_dreq    = (dREN_mem | dWEN_mem) & ~r_dmem_mask;
  assign w_advance = ihit & (~w_dreq | dhit) & (r_state != HALT);

  // Register zero never carries a real dependency, so it cannot cause a load-use stall.
  assign w_loaduse = memRead_ex && (regDest_ex != 5'd0) &&
                     ((regDest_ex == rs_id) || (useRt_id && (regDest_ex == rt_id)));

  // A redirect discards the dependent instruction anyway, so it overrides the load-use hold.
  assign w_hold_front = w_loaduse & ~redirect_mem;

  assign pc_en       = w_advance & ~w_hold_front;
  assign en_ifid     = w_advance & ~w_hold_front;
  assign en_idex     = w_advance;
  assign en_exmem    = w_advance;
  assign en_memwb    = w_advance;
  assign flush_ifid  = w_advance & redirect_mem;
  assign flush_idex  = w_advance & (redirect_mem | w_loaduse);
  assign flush_exmem = w_advance & redirect_mem;

  assign dmem_mask = r_dmem_mask;
  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;

  // Control state machine with registered mask and halt outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_dmem_mask <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_advance && halt_mem) begin
            r_state     <= HALT;
            r_dmem_mask <= 1'b0;
            r_halt      <= 1'b1;
          end else if (w_dreq && dhit && !ihit) begin
            r_state     <= DDONE;
            r_dmem_mask <= 1'b1;
          end
        end
        DDONE: begin
          if (w_advance && halt_mem) begin
            r_state     <= HALT;
            r_dmem_mask <= 1'b0;
            r_halt      <= 1'b1;
          end else if (ihit) begin
            r_state     <= RUN;
            r_dmem_mask <= 1'b0;
          end
        end
        HALT: begin
          r_state     <= HALT;
          r_dmem_mask <= 1'b0;
          r_halt      <= 1'b1;
        end
        default: begin
          r_state     <= RUN;
          r_dmem_mask <= 1'b0;
          r_halt      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the pipeline could not advance, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if ((r_state != HALT) && !w_advance && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
